pe_seq_ctrl: RTL

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

---
 rtl/pe_pkg.sv | 69 ++++++
 rtl/pe_stream_port.sv | 70 +++++++
 rtl/pe_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// ============================================================================
// Module      : pe_pkg
// Description : Shared definitions for the PE sequencing controller: config
//               field offsets, derived-count widths, state encodings and
//               small arithmetic helpers. Also provides CONFIG_SIZE and
//               DATA_BITS when the build does not supply them.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef CONFIG_SIZE
`define CONFIG_SIZE 13
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

`default_nettype none

package pe_pkg;

  // cfg layout: depthwise[12] rs-1[11:10] mode[9] p-1[8:7] F[6:2] q-1[1:0]
  localparam int CFG_DW_BIT   = 12;
  localparam int CFG_RS_LSB   = 10;
  localparam int CFG_MODE_BIT = 9;
  localparam int CFG_P_LSB    = 7;
  localparam int CFG_F_LSB    = 2;
  localparam int CFG_Q_LSB    = 0;

  // Dimensions are 1..4, word counts reach RS*Q+P*Q = 32, columns up to 32
  localparam int DIM_BITS = 3;
  localparam int CNT_BITS = 6;
  localparam int COL_BITS = 5;
  localparam int PW_WORDS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CFG     = 3'd1,
    ST_FILT    = 3'd2,
    ST_IFMAP   = 3'd3,
    ST_IPSUM   = 3'd4,
    ST_PWIPSUM = 3'd5,
    ST_OPSUM   = 3'd6,
    ST_DONE    = 3'd7
  } seq_state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_WAIT = 2'd1,
    PH_HOLD = 2'd2
  } port_phase_e;

  // A stored "minus one" field turned into its real dimension
  function automatic logic [DIM_BITS-1:0] fld_plus1(input logic [1:0] f);
    return {1'b0, f} + 3'd1;
  endfunction

  // Dimension widened to the word-count width
  function automatic logic [CNT_BITS-1:0] widen(input logic [DIM_BITS-1:0] d);
    return {{(CNT_BITS-DIM_BITS){1'b0}}, d};
  endfunction

  // Product of two dimensions as a word count
  function automatic logic [CNT_BITS-1:0] mul_dim(input logic [DIM_BITS-1:0] a,
                                                  input logic [DIM_BITS-1:0] b);
    return widen(a) * widen(b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_stream_port.sv
// ============================================================================
// Module      : pe_stream_port
// Description : One PE input stream. Issues a GLB read, captures the read
//               data the following cycle, then holds data/valid until the PE
//               takes the word. The parent owns pointer and word counting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_stream_port
  import pe_pkg::*;
#(
  parameter int DATA_W = `DATA_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ready,
  output logic              rd_req,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              xfer
);

  port_phase_e       phase_q, phase_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  // Read request, capture of returned data, and hold until accepted
  always_comb begin
    phase_d = phase_q;
    data_d  = data_q;
    valid_d = valid_q;
    rd_req  = en && (phase_q == PH_IDLE);
    xfer    = valid_q && ready;
    case (phase_q)
      PH_IDLE: if (en) phase_d = PH_WAIT;
      PH_WAIT: begin
        data_d  = rdata;
        valid_d = 1'b1;
        phase_d = PH_HOLD;
      end
      PH_HOLD: if (ready) begin
        valid_d = 1'b0;
        phase_d = PH_IDLE;
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  // Phase and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/pe_seq_ctrl.sv
// ============================================================================
// Module      : pe_seq_ctrl
// Description : Sequences one PE pass: loads the config, streams filter,
//               ifmap and ipsum words from the GLB into the PE and writes the
//               PE results back, column by column.
//               Optional macro PE_SEQ_DW_EN adds the depthwise/pointwise path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_seq_ctrl #(
  parameter int ADDR_BITS = 16,
  parameter int CFG_BITS  = `CONFIG_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CFG_BITS-1:0]  cfg,
  input  logic [ADDR_BITS-1:0] filter_base,
  input  logic [ADDR_BITS-1:0] ifmap_base,
  input  logic [ADDR_BITS-1:0] ipsum_base,
  input  logic [ADDR_BITS-1:0] opsum_base,
  output logic                 busy,
  output logic                 done,
  output logic                 PE_en,
  output logic [CFG_BITS-1:0]  i_config,
  output logic [31:0]          filter,
  output logic [31:0]          ifmap,
  output logic [31:0]          depthwise_ipsum,
  output logic                 filter_valid,
  output logic                 ifmap_valid,
  output logic                 depthwise_ipsum_valid,
  input  logic                 filter_ready,
  input  logic                 ifmap_ready,
  input  logic                 depthwise_ipsum_ready,
`ifdef PE_SEQ_DW_EN
  output logic [31:0]          pointwise_ipsum,
  output logic                 pointwise_ipsum_valid,
  input  logic                 pointwise_ipsum_ready,
`endif
  input  logic [31:0]          opsum,
  input  logic                 opsum_valid,
  output logic                 opsum_ready,
  output logic                 glb_req,
  output logic                 glb_we,
  output logic [ADDR_BITS-1:0] glb_addr,
  output logic [31:0]          glb_wdata,
  input  logic [31:0]          glb_rdata
);

  import pe_pkg::*;

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  seq_state_e           state_q, state_d;
  logic [CFG_BITS-1:0]  cfg_q, cfg_d;
  logic [ADDR_BITS-1:0] filt_ptr_q, filt_ptr_d, ifmap_ptr_q, ifmap_ptr_d;
  logic [ADDR_BITS-1:0] ipsum_ptr_q, ipsum_ptr_d, opsum_ptr_q, opsum_ptr_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic busy_q, busy_d, done_q, done_d, pe_en_q, pe_en_d, opsum_ready_q, opsum_ready_d;

  logic                dw;
  logic [DIM_BITS-1:0] p_dim, rs_dim, q_dim;
  logic [COL_BITS-1:0] f_fld;
  logic [CNT_BITS-1:0] filt_words, ifmap_words, ipsum_words, word_target;
  logic filt_rd, ifmap_rd, ipsum_rd, pw_rd;
  logic filt_xfer, ifmap_xfer, ipsum_xfer, pw_xfer, op_xfer;
  logic word_xfer, last_word;

  // Derived dimensions come from the latched config only
  assign p_dim  = fld_plus1(cfg_q[CFG_P_LSB +: 2]);
  assign rs_dim = fld_plus1(cfg_q[CFG_RS_LSB +: 2]);
  assign q_dim  = fld_plus1(cfg_q[CFG_Q_LSB +: 2]);
  assign f_fld  = cfg_q[CFG_F_LSB +: COL_BITS];
`ifdef PE_SEQ_DW_EN
  assign dw = cfg_q[CFG_DW_BIT];
`else
  assign dw = 1'b0;
`endif

  assign filt_words  = dw ? (mul_dim(rs_dim, q_dim) + mul_dim(p_dim, q_dim))
                          : mul_dim(p_dim, rs_dim);
  assign ifmap_words = (col_q == '0) ? widen(rs_dim) : CNT_BITS'(1);
  assign ipsum_words = dw ? widen(q_dim) : widen(p_dim);
  assign op_xfer     = opsum_valid && opsum_ready_q;

  pe_stream_port #(.DATA_W(32)) u_filt_port (
    .clk(clk), .rst(rst), .en(state_q == ST_FILT), .rdata(glb_rdata),
    .ready(filter_ready), .rd_req(filt_rd), .data(filter),
    .valid(filter_valid), .xfer(filt_xfer)
  );

  pe_stream_port #(.DATA_W(32)) u_ifmap_port (
    .clk(clk), .rst(rst), .en(state_q == ST_IFMAP), .rdata(glb_rdata),
    .ready(ifmap_ready), .rd_req(ifmap_rd), .data(ifmap),
    .valid(ifmap_valid), .xfer(ifmap_xfer)
  );

  pe_stream_port #(.DATA_W(32)) u_ipsum_port (
    .clk(clk), .rst(rst), .en(state_q == ST_IPSUM), .rdata(glb_rdata),
    .ready(depthwise_ipsum_ready), .rd_req(ipsum_rd), .data(depthwise_ipsum),
    .valid(depthwise_ipsum_valid), .xfer(ipsum_xfer)
  );

`ifdef PE_SEQ_DW_EN
  pe_stream_port #(.DATA_W(32)) u_pw_port (
    .clk(clk), .rst(rst), .en(state_q == ST_PWIPSUM), .rdata(glb_rdata),
    .ready(pointwise_ipsum_ready), .rd_req(pw_rd), .data(pointwise_ipsum),
    .valid(pointwise_ipsum_valid), .xfer(pw_xfer)
  );
`else
  assign pw_rd   = 1'b0;
  assign pw_xfer = 1'b0;
`endif

  // Next state, pointer advance and word/column counting
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    filt_ptr_d  = filt_ptr_q;
    ifmap_ptr_d = ifmap_ptr_q;
    ipsum_ptr_d = ipsum_ptr_q;
    opsum_ptr_d = opsum_ptr_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    word_xfer   = 1'b0;
    word_target = '0;
    case (state_q)
      ST_FILT:    begin word_xfer = filt_xfer;  word_target = filt_words;  end
      ST_IFMAP:   begin word_xfer = ifmap_xfer; word_target = ifmap_words; end
      ST_IPSUM:   begin word_xfer = ipsum_xfer; word_target = ipsum_words; end
      ST_PWIPSUM: begin word_xfer = pw_xfer;    word_target = CNT_BITS'(PW_WORDS); end
      ST_OPSUM:   begin word_xfer = op_xfer;    word_target = widen(p_dim); end
      default:    ;
    endcase
    last_word = word_xfer && ((cnt_q + CNT_BITS'(1)) == word_target);
    if (word_xfer) cnt_d = last_word ? '0 : cnt_q + CNT_BITS'(1);

    case (state_q)
      ST_IDLE: if (start) begin
        state_d     = ST_CFG;
        cfg_d       = cfg;
        filt_ptr_d  = filter_base;
        ifmap_ptr_d = ifmap_base;
        ipsum_ptr_d = ipsum_base;
        opsum_ptr_d = opsum_base;
        cnt_d       = '0;
        col_d       = '0;
      end
      ST_CFG: state_d = ST_FILT;
      ST_FILT: begin
        if (word_xfer) filt_ptr_d = filt_ptr_q + ADDR_ONE;
        if (last_word) state_d = ST_IFMAP;
      end
      ST_IFMAP: begin
        if (word_xfer) ifmap_ptr_d = ifmap_ptr_q + ADDR_ONE;
        if (last_word) state_d = ST_IPSUM;
      end
      ST_IPSUM: begin
        if (word_xfer) ipsum_ptr_d = ipsum_ptr_q + ADDR_ONE;
        if (last_word) state_d = dw ? ST_PWIPSUM : ST_OPSUM;
      end
      // Pointwise words sit directly after the depthwise ipsum words
      ST_PWIPSUM: begin
        if (word_xfer) ipsum_ptr_d = ipsum_ptr_q + ADDR_ONE;
        if (last_word) state_d = ST_OPSUM;
      end
      ST_OPSUM: begin
        if (word_xfer) opsum_ptr_d = opsum_ptr_q + ADDR_ONE;
        if (last_word) begin
          col_d   = col_q + COL_BITS'(1);
          state_d = (col_q == f_fld) ? ST_DONE : ST_IFMAP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cfg_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
    pe_en_d       = (state_d == ST_CFG);
    opsum_ready_d = (state_d == ST_OPSUM);
  end

  // Controller registers; all outputs register from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cfg_q         <= '0;
      filt_ptr_q    <= '0;
      ifmap_ptr_q   <= '0;
      ipsum_ptr_q   <= '0;
      opsum_ptr_q   <= '0;
      cnt_q         <= '0;
      col_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pe_en_q       <= 1'b0;
      opsum_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_q         <= cfg_d;
      filt_ptr_q    <= filt_ptr_d;
      ifmap_ptr_q   <= ifmap_ptr_d;
      ipsum_ptr_q   <= ipsum_ptr_d;
      opsum_ptr_q   <= opsum_ptr_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pe_en_q       <= pe_en_d;
      opsum_ready_q <= opsum_ready_d;
    end
  end

  // GLB port: result writes and the single active stream's read
  always_comb begin
    glb_req   = 1'b0;
    glb_we    = 1'b0;
    glb_addr  = '0;
    glb_wdata = '0;
    if (op_xfer) begin
      glb_req   = 1'b1;
      glb_we    = 1'b1;
      glb_addr  = opsum_ptr_q;
      glb_wdata = opsum;
    end else if (filt_rd) begin
      glb_req  = 1'b1;
      glb_addr = filt_ptr_q;
    end else if (ifmap_rd) begin
      glb_req  = 1'b1;
      glb_addr = ifmap_ptr_q;
    end else if (ipsum_rd || pw_rd) begin
      glb_req  = 1'b1;
      glb_addr = ipsum_ptr_q;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign PE_en       = pe_en_q;
  assign i_config    = cfg_q;
  assign opsum_ready = opsum_ready_q;

endmodule

`default_nettype wire
